imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word written.
REQ-002 Parameter: MAX_WORDS, default 256, instruction memory capacity in 32-bit words.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_data  input  8  boot stream byte.
REQ-006 Port: in_valid  input  1  in_data holds a valid byte.
REQ-007 Port: in_ready  output  1  loader accepts a byte this cycle.
REQ-008 Port: imem_we  output  1  one-cycle write strobe to instruction memory.
REQ-009 Port: imem_addr  output  32  byte address of the word being written.
REQ-010 Port: imem_wdata  output  32  instruction word being written.
REQ-011 Port: cpu_reset  output  1  active-high reset driven to the processor; high until the load completes.
REQ-012 Port: done  output  1  load completed successfully (sticky).
REQ-013 Port: error  output  1  header exceeded MAX_WORDS (sticky).
REQ-014 There is one clock; reset is synchronous and active-high, and the ports are named clk and reset.

Function
REQ-015 A byte transfer occurs only in a cycle where in_valid=1 and in_ready=1.
REQ-016 Stream format: a 2-byte word count N (big-endian, first byte = N[15:8]), followed by N words of 4 bytes each, big-endian (first byte = bits 31:24).
REQ-017 The FSM states are LEN_HI, LEN_LO, WORD, WRITE, DONE, ERR.
REQ-018 In LEN_HI, an accepted byte is stored as N[15:8] and the FSM moves to LEN_LO.
REQ-019 In LEN_LO, an accepted byte completes N. Then: N=0 -> DONE; N>MAX_WORDS -> ERR; otherwise -> WORD with the word index and byte counter cleared.
REQ-020 In WORD, accepted bytes shift into a 32-bit assembly register. The 2-bit byte counter wraps 3->0; acceptance of the 4th byte moves the FSM to WRITE.
REQ-021 While in WRITE (exactly one cycle), the outputs are imem_we=1, imem_addr=BASE_ADDR+4*index (32-bit, modulo 2^32), and imem_wdata=the assembled word.
REQ-022 Leaving WRITE, the word index increments. The FSM goes to DONE if index+1 = N, otherwise to WORD.
REQ-023 in_ready=1 only in LEN_HI, LEN_LO and WORD; it is 0 in WRITE, DONE and ERR.
REQ-024 Latency: 4th byte accepted in cycle t -> imem_we=1 in cycle t+1 -> in_ready=1 again in cycle t+2.
REQ-025 Outside WRITE, imem_we=0; imem_addr and imem_wdata hold their last values.
REQ-026 In DONE: done=1 and cpu_reset=0, starting the cycle after the last write. Both are sticky until reset; bytes are ignored.
REQ-027 In ERR: error=1 and cpu_reset=1, and no imem write occurs. Both are sticky until reset.
REQ-028 Gaps in in_valid (in_valid=0) stall the FSM in its current state with no loss of partial bytes.
REQ-029 done and error are never 1 simultaneously.

Reset
REQ-030 reset=1 at a clock edge forces, in the next cycle: state=LEN_HI, index=0, byte counter=0, assembly register=0, N=0.
REQ-031 The same reset forces the outputs: imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0, in_ready=1.
REQ-032 Reset has priority over any simultaneous handshake: a byte presented with reset=1 is not consumed.
REQ-033 Reset mid-load (any state) discards the partial word and count. The next accepted byte is treated as N[15:8].

Verification
REQ-034 Stream 00 02 | 20 08 00 05 | 08 00 00 00 with continuous valid -> two writes: (addr 0x0, data 0x20080005), then (addr 0x4, data 0x08000000); done=1 and cpu_reset=0 one cycle after the 2nd write.
REQ-035 Stream 00 00 -> no imem_we pulse; done=1 and cpu_reset=0 the cycle after the 2nd byte is accepted.
REQ-036 Header 01 01 (N=257) with MAX_WORDS=256 -> error=1, cpu_reset stays 1, no writes, in_ready=0 thereafter.
REQ-037 Same stream as REQ-034 with in_valid toggled 1/0 every cycle -> identical writes and data; in_ready=0 exactly during WRITE cycles.
REQ-038 Reset asserted after 2 bytes of the first word -> state LEN_HI. A fresh stream 00 01 | DE AD BE EF then writes 0xDEADBEEF to BASE_ADDR and asserts done.
REQ-039 After done=1, further valid bytes -> in_ready=0, no writes, and done and cpu_reset unchanged.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-stream loader that fills instruction memory and releases the CPU
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        WORD,
        WRITE,
        DONE,
        ERR
    } stateType;

    stateType    state;
    stateType    nextState;
    logic [15:0] wordCount;
    logic [15:0] wordIndex;
    logic [1:0]  byteCnt;
    logic [31:0] asmWord;
    logic        accept;
    logic [15:0] fullCount;

    assign accept    = in_valid & in_ready;
    // Header count as it becomes complete on the low byte.
    assign fullCount = {wordCount[15:8], in_data};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LEN_HI;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        imem_we   = 1'b0;
        cpu_reset = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            LEN_HI: begin
                in_ready = 1'b1;
                if (accept) begin
                    nextState = LEN_LO;
                end
            end
            LEN_LO: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (fullCount == 16'd0) begin
                        nextState = DONE;
                    end else if (32'(fullCount) > 32'(MAX_WORDS)) begin
                        nextState = ERR;
                    end else begin
                        nextState = WORD;
                    end
                end
            end
            WORD: begin
                in_ready = 1'b1;
                if (accept && byteCnt == 2'd3) begin
                    nextState = WRITE;
                end
            end
            WRITE: begin
                imem_we = 1'b1;
                if (wordIndex + 16'd1 == wordCount) begin
                    nextState = DONE;
                end else begin
                    nextState = WORD;
                end
            end
            DONE: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            ERR: begin
                error = 1'b1;
            end
            default: begin
                nextState = LEN_HI;
            end
        endcase
    end

    // Header capture, word assembly, and the write-port registers that hold
    // their last value between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wordCount  <= 16'd0;
            wordIndex  <= 16'd0;
            byteCnt    <= 2'd0;
            asmWord    <= 32'd0;
            imem_addr  <= 32'd0;
            imem_wdata <= 32'd0;
        end else begin
            case (state)
                LEN_HI: begin
                    if (accept) begin
                        wordCount[15:8] <= in_data;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        wordCount[7:0] <= in_data;
                        wordIndex      <= 16'd0;
                        byteCnt        <= 2'd0;
                    end
                end
                WORD: begin
                    if (accept) begin
                        asmWord <= {asmWord[23:0], in_data};
                        byteCnt <= byteCnt + 2'd1;
                        if (byteCnt == 2'd3) begin
                            imem_addr  <= BASE_ADDR + 32'({wordIndex, 2'b00});
                            imem_wdata <= {asmWord[23:0], in_data};
                        end
                    end
                end
                WRITE: begin
                    wordIndex <= wordIndex + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
